// File: rtl/cmp_scheduler.sv
// cmp_scheduler
//   Round-robin front end that shares one pipelined FP less-than comparator
//   (FloPoCo 11/18, 32-bit words) among N requesters. One request is accepted
//   per cycle. The requester ID rides a tag pipeline matched to the comparator
//   latency, so each result returns to the requester that issued it.
//
// Ports
//   clk, rst            single rising-edge clock, synchronous active-high reset
//   req_valid[N]        per-requester request valid
//   req_ready[N]        one-hot grant (combinational); accept = valid & ready
//   req_a/req_b[N*W]    flattened operands, requester i at [i*WIDTH +: WIDTH]
//   cmp_a/cmp_b[W]      registered operands to the comparator
//   cmp_less            comparator result, CMP_LAT cycles after cmp_a/cmp_b
//   rsp_valid[N]        one-hot single-cycle response strobe (registered)
//   rsp_less            result for the strobed requester (registered)
//   inflight            accepted requests not yet responded
module cmp_scheduler #(
  parameter int N       = 4,
  parameter int WIDTH   = 32,
  parameter int CMP_LAT = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N-1:0]                  req_valid,
  output logic [N-1:0]                  req_ready,
  input  logic [N*WIDTH-1:0]            req_a,
  input  logic [N*WIDTH-1:0]            req_b,
  output logic [WIDTH-1:0]              cmp_a,
  output logic [WIDTH-1:0]              cmp_b,
  input  logic                          cmp_less,
  output logic [N-1:0]                  rsp_valid,
  output logic                          rsp_less,
  output logic [$clog2(CMP_LAT+2)-1:0]  inflight
);

  localparam int IDW = (N > 1) ? $clog2(N) : 1;
  localparam int CW  = $clog2(CMP_LAT + 2);

  // ---------------------------------------------------------------- arbiter
  logic [IDW-1:0] rr_q, rr_d;
  logic           grant_vld;
  logic [IDW-1:0] grant_id;
  logic [IDW:0]   cand;

  // Scan rr, rr+1, ... mod N; the extra bit in cand absorbs the wrap.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    req_ready = '0;
    cand      = '0;
    for (int off = 0; off < N; off++) begin
      cand = {1'b0, rr_q} + (IDW+1)'(off);
      if (cand >= (IDW+1)'(N)) cand = cand - (IDW+1)'(N);
      if (!grant_vld && !rst && req_valid[cand[IDW-1:0]]) begin
        grant_vld = 1'b1;
        grant_id  = cand[IDW-1:0];
      end
    end
    if (grant_vld) req_ready[grant_id] = 1'b1;
  end

  always_comb begin
    rr_d = rr_q;
    if (grant_vld) rr_d = (grant_id == IDW'(N-1)) ? '0 : grant_id + IDW'(1);
  end

  // ------------------------------------------------------------------ issue
  logic [WIDTH-1:0] cmp_a_q, cmp_a_d, cmp_b_q, cmp_b_d;

  // Operands hold when idle; the comparator output is simply not tagged.
  always_comb begin
    cmp_a_d = cmp_a_q;
    cmp_b_d = cmp_b_q;
    if (grant_vld) begin
      cmp_a_d = req_a[grant_id*WIDTH +: WIDTH];
      cmp_b_d = req_b[grant_id*WIDTH +: WIDTH];
    end
  end

  // ------------------------------------------------------------ tag pipeline
  // Stage 0 is loaded at the accept edge, so stage CMP_LAT lines up with the
  // cycle in which cmp_less belongs to that request.
  logic [CMP_LAT:0]          vld_pipe_q, vld_pipe_d;
  logic [CMP_LAT:0][IDW-1:0] id_pipe_q,  id_pipe_d;
  logic                      rsp_fire;

  always_comb begin
    vld_pipe_d = {vld_pipe_q[CMP_LAT-1:0], grant_vld};
    id_pipe_d  = {id_pipe_q[CMP_LAT-1:0], grant_id};
  end

  assign rsp_fire = vld_pipe_q[CMP_LAT];

  logic [N-1:0] rsp_valid_q, rsp_valid_d;
  logic         rsp_less_q, rsp_less_d;

  always_comb begin
    rsp_valid_d = '0;
    rsp_less_d  = 1'b0;
    if (rsp_fire) begin
      rsp_valid_d[id_pipe_q[CMP_LAT]] = 1'b1;
      rsp_less_d                      = cmp_less;
    end
  end

  // --------------------------------------------------------------- inflight
  logic [CW-1:0] inflight_q, inflight_d;

  always_comb begin
    inflight_d = inflight_q;
    case ({grant_vld, rsp_fire})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  // -------------------------------------------------------------- registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q        <= '0;
      cmp_a_q     <= '0;
      cmp_b_q     <= '0;
      vld_pipe_q  <= '0;
      id_pipe_q   <= '0;
      rsp_valid_q <= '0;
      rsp_less_q  <= 1'b0;
      inflight_q  <= '0;
    end else begin
      rr_q        <= rr_d;
      cmp_a_q     <= cmp_a_d;
      cmp_b_q     <= cmp_b_d;
      vld_pipe_q  <= vld_pipe_d;
      id_pipe_q   <= id_pipe_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_less_q  <= rsp_less_d;
      inflight_q  <= inflight_d;
    end
  end

  assign cmp_a     = cmp_a_q;
  assign cmp_b     = cmp_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_less  = rsp_less_q;
  assign inflight  = inflight_q;

endmodule

// File: tb/tb_cmp_scheduler.sv
module tb_cmp_scheduler;
  localparam int N   = 4;
  localparam int W   = 32;
  localparam int LAT = 2;
  localparam logic [31:0] ONE = 32'h4FFC0000;
  localparam logic [31:0] TWO = 32'h50000000;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [N-1:0]               req_valid;
  logic [N-1:0]               req_ready;
  logic [N*W-1:0]             req_a, req_b;
  logic [W-1:0]               cmp_a, cmp_b;
  logic                       cmp_less;
  logic [N-1:0]               rsp_valid;
  logic                       rsp_less;
  logic [$clog2(LAT+2)-1:0]   inflight;

  always #5 clk = ~clk;

  cmp_scheduler #(.N(N), .WIDTH(W), .CMP_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .cmp_a(cmp_a), .cmp_b(cmp_b),
    .cmp_less(cmp_less), .rsp_valid(rsp_valid), .rsp_less(rsp_less),
    .inflight(inflight)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Normal FloPoCo numbers only: sign-magnitude compare on {exp,frac}.
  function automatic bit fp_less(input logic [31:0] a, input logic [31:0] b);
    if (a[29] != b[29]) return a[29];
    if (a[29] == 1'b0) return a[28:0] < b[28:0];
    return a[28:0] > b[28:0];
  endfunction

  // Comparator stand-in with LAT cycles of latency.
  logic [LAT-1:0] cpipe;
  always @(posedge clk) begin
    cpipe[0] <= fp_less(cmp_a, cmp_b);
    for (int i = 1; i < LAT; i++) cpipe[i] <= cpipe[i-1];
  end
  assign cmp_less = cpipe[LAT-1];

  // ------------------------------------------------------- reference model
  typedef struct { int due; int id; bit less; } ent_t;
  ent_t        q[$];
  int          cyc = 0;
  int          m_rr = 0;
  logic [31:0] m_cmp_a = 0, m_cmp_b = 0;
  logic [N-1:0] m_rsp_valid = 0;
  bit          m_rsp_less = 0;
  bit          started = 0;

  function automatic int pick(input int rr, input logic [N-1:0] v, input logic r);
    if (r) return -1;
    for (int off = 0; off < N; off++)
      if (v[(rr + off) % N]) return (rr + off) % N;
    return -1;
  endfunction

  always @(posedge clk) begin
    int g;
    cyc++;
    started = 1;
    if (rst) begin
      q.delete();
      m_rr = 0; m_cmp_a = 0; m_cmp_b = 0; m_rsp_valid = 0; m_rsp_less = 0;
    end else begin
      m_rsp_valid = 0;
      m_rsp_less  = 0;
      if (q.size() > 0 && q[0].due == cyc) begin
        m_rsp_valid[q[0].id] = 1'b1;
        m_rsp_less = q[0].less;
        void'(q.pop_front());
      end
      g = pick(m_rr, req_valid, rst);
      if (g >= 0) begin
        m_cmp_a = req_a[g*W +: W];
        m_cmp_b = req_b[g*W +: W];
        q.push_back('{due: cyc + LAT + 1, id: g, less: fp_less(m_cmp_a, m_cmp_b)});
        m_rr = (g + 1) % N;
      end
    end
  end

  always @(negedge clk) begin
    int g;
    logic [N-1:0] er;
    if (started) begin
      er = '0;
      g = pick(m_rr, req_valid, rst);
      if (g >= 0) er[g] = 1'b1;
      chk("req_ready", req_ready, er);
      chk("rsp_valid", rsp_valid, m_rsp_valid);
      chk("rsp_less",  rsp_less,  m_rsp_less);
      chk("inflight",  inflight,  q.size());
      chk("cmp_a",     cmp_a,     m_cmp_a);
      chk("cmp_b",     cmp_b,     m_cmp_b);
    end
  end

  // --------------------------------------------------------------- stimulus
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  function automatic logic [31:0] rnd_num();
    return {2'b01, 1'($urandom), 11'($urandom), 18'($urandom)};
  endfunction

  initial begin
    logic [31:0] held;
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
    chk("model_1lt2", fp_less(ONE, TWO), 1);
    chk("model_2lt1", fp_less(TWO, ONE), 0);
    repeat (3) step();
    @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_cmp_a", cmp_a, 0);

    // Single request, accepted in the first cycle out of reset.
    step();
    rst = 1'b0; req_valid = 4'b0001; set_req(0, ONE, TWO);
    @(negedge clk); chk("single_ready", req_ready, 4'b0001);
    step(); req_valid = '0;
    @(negedge clk); chk("single_inflight1", inflight, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("single_rsp", rsp_valid, 4'b0001);
    chk("single_less", rsp_less, 1);
    chk("single_inflight0", inflight, 0);

    // Fairness from rr=0.
    step(); rst = 1'b1;
    step(); rst = 1'b0; req_valid = 4'hF;
    for (int i = 0; i < 4; i++) set_req(i, rnd_num(), rnd_num());
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); chk("fair_grant", req_ready, 4'b0001 << (i % 4));
      step();
    end
    req_valid = '0;
    repeat (6) step();

    // Result routing: req1 then req2.
    set_req(1, TWO, ONE); set_req(2, ONE, TWO);
    req_valid = 4'b0010; step();
    req_valid = 4'b0100; step();
    req_valid = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); chk("route1_v", rsp_valid, 4'b0010); chk("route1_l", rsp_less, 0);
    @(posedge clk);
    @(negedge clk); chk("route2_v", rsp_valid, 4'b0100); chk("route2_l", rsp_less, 1);

    // Pointer skip with rr=1.
    step(); rst = 1'b1;
    step(); rst = 1'b0; req_valid = 4'b0001;
    step(); req_valid = 4'b1001;
    @(negedge clk); chk("skip_first", req_ready, 4'b1000);
    step();
    @(negedge clk); chk("skip_second", req_ready, 4'b0001);
    step(); req_valid = 4'hF;
    @(negedge clk); chk("skip_rr1", req_ready, 4'b0010);
    step(); req_valid = '0;
    repeat (6) step();

    // Reset mid-flight after the second of three responses.
    req_valid = 4'b0001; step();
    req_valid = 4'b0010; step();
    req_valid = 4'b0100; step();
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk); chk("midrst_2nd", rsp_valid, 4'b0010);
    step(); rst = 1'b0;
    @(negedge clk);
    chk("midrst_rsp", rsp_valid, 0);
    chk("midrst_less", rsp_less, 0);
    chk("midrst_inflight", inflight, 0);
    chk("midrst_cmp_a", cmp_a, 0);
    repeat (4) step();

    // Idle hold after one request.
    held = rnd_num();
    set_req(2, held, ONE); req_valid = 4'b0100; step();
    req_valid = '0;
    repeat (10) step();
    @(negedge clk);
    chk("idle_cmp_a", cmp_a, held);
    chk("idle_cmp_b", cmp_b, ONE);
    chk("idle_rsp", rsp_valid, 0);
    chk("idle_inflight", inflight, 0);

    // Randomized traffic with occasional resets.
    for (int t = 0; t < 3000; t++) begin
      step();
      rst = ($urandom_range(0, 199) == 0);
      req_valid = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) begin
          held = rnd_num(); set_req(i, held, held);
        end else set_req(i, rnd_num(), rnd_num());
      end
    end
    step(); rst = 1'b0; req_valid = '0;
    repeat (8) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
